// File: rtl/a2d_arbiter_if.sv
// Bundle of the two requester ports plus the shared A2D converter handshake.
// The arbiter takes the slave modport; the requesters/converter side takes master.
interface a2d_arbiter_if;
  logic        req0;
  logic [2:0]  chnnl0;
  logic        done0;
  logic [11:0] res0;
  logic        tout0;
  logic        req1;
  logic [2:0]  chnnl1;
  logic        done1;
  logic [11:0] res1;
  logic        tout1;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        busy;

  modport slave (
    input  req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
    output done0, res0, tout0, done1, res1, tout1, strt_cnv, chnnl, busy
  );

  modport master (
    output req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
    input  done0, res0, tout0, done1, res1, tout1, strt_cnv, chnnl, busy
  );
endinterface

// File: rtl/a2d_arbiter.sv
// Two-port arbiter for the shared 8-channel A2D converter with a conversion watchdog.
// Optional macro A2D_ARB_RR_EN selects round-robin tie-breaking; default is fixed priority to port 0.
module a2d_arbiter #(
  parameter int TIMEOUT = 512,
  parameter int TO_W    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  a2d_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic            pend0;
  logic            pend1;
  logic [2:0]      ch0;
  logic [2:0]      ch1;
  logic            owner;
  logic            grant_sel;
  logic            cmplt_q;
  logic            cmplt_rise;
  logic            wdog_exp;
  logic [TO_W-1:0] wdog;
`ifdef A2D_ARB_RR_EN
  logic            last_owner;
`endif

  // cnv_cmplt may still be high from the previous conversion, so only a fresh rise
  // outside the strt_cnv cycle counts as completion.
  assign cmplt_rise = bus.cnv_cmplt & ~cmplt_q & ~bus.strt_cnv;
  assign wdog_exp   = (wdog == TO_W'(TIMEOUT - 1));

  always_comb begin
    grant_sel = ~pend0;
`ifdef A2D_ARB_RR_EN
    if (pend0 && pend1)
      grant_sel = ~last_owner;
`endif
  end

  // Pending channel holding registers; a repeat request simply overwrites.
  always_ff @(posedge clk) begin
    if (bus.req0) ch0 <= bus.chnnl0;
    if (bus.req1) ch1 <= bus.chnnl1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend0        <= 1'b0;
      pend1        <= 1'b0;
      owner        <= 1'b0;
      cmplt_q      <= 1'b0;
      wdog         <= '0;
      bus.strt_cnv <= 1'b0;
      bus.chnnl    <= 3'd0;
      bus.busy     <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.res0     <= 12'h000;
      bus.res1     <= 12'h000;
      bus.tout0    <= 1'b0;
      bus.tout1    <= 1'b0;
`ifdef A2D_ARB_RR_EN
      last_owner   <= 1'b1;
`endif
    end else begin
      bus.strt_cnv <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      cmplt_q      <= bus.cnv_cmplt;
      if (bus.req0) pend0 <= 1'b1;
      if (bus.req1) pend1 <= 1'b1;

      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            owner        <= grant_sel;
`ifdef A2D_ARB_RR_EN
            last_owner   <= grant_sel;
`endif
            // A same-cycle request from the winner re-arms its pending flag.
            if (!grant_sel && !bus.req0) pend0 <= 1'b0;
            if (grant_sel && !bus.req1)  pend1 <= 1'b0;
            bus.chnnl    <= grant_sel ? ch1 : ch0;
            bus.strt_cnv <= 1'b1;
            bus.busy     <= 1'b1;
            wdog         <= '0;
            state        <= WAIT;
          end
        end

        WAIT: begin
          wdog <= wdog + TO_W'(1);
          if (cmplt_rise || wdog_exp) begin
            if (owner) begin
              bus.res1  <= cmplt_rise ? bus.A2D_res : 12'h000;
              bus.tout1 <= ~cmplt_rise;
              bus.done1 <= 1'b1;
            end else begin
              bus.res0  <= cmplt_rise ? bus.A2D_res : 12'h000;
              bus.tout0 <= ~cmplt_rise;
              bus.done0 <= 1'b1;
            end
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
